// File: rtl/conway_pkg.sv
// Shared types and B3/S23 rule constants for the Conway rule engine.
package conway_pkg;

  localparam int unsigned CONWAY_NUM_NEIGHBORS = 8;
  localparam int unsigned CONWAY_COUNT_WIDTH   = 4;

  typedef logic [CONWAY_COUNT_WIDTH-1:0] conway_count_t;

  localparam logic [CONWAY_NUM_NEIGHBORS:0] CONWAY_B3S23_BIRTH   = 9'b0_0000_1000;
  localparam logic [CONWAY_NUM_NEIGHBORS:0] CONWAY_B3S23_SURVIVE = 9'b0_0000_1100;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } rule_state_t;

endpackage

// File: rtl/conway_rule_lut.sv
// Combinational birth/survive lookup: (count, cur_state, masks) -> next state.
module conway_rule_lut
  import conway_pkg::*;
#(
  parameter int unsigned NUM_NEIGHBORS = CONWAY_NUM_NEIGHBORS,
  parameter int unsigned COUNT_WIDTH   = CONWAY_COUNT_WIDTH
) (
  input  logic [COUNT_WIDTH-1:0]   count,
  input  logic                     cur_state,
  input  logic [NUM_NEIGHBORS:0]   birth_mask,
  input  logic [NUM_NEIGHBORS:0]   survive_mask,
  output logic                     next_state_c
);

  localparam int unsigned LUT_DEPTH = 2 ** COUNT_WIDTH;

  logic [LUT_DEPTH-1:0] birth_ext;
  logic [LUT_DEPTH-1:0] survive_ext;

  // Masks are widened to the full count range so any count indexes in bounds.
  always_comb begin
    birth_ext    = LUT_DEPTH'(birth_mask);
    survive_ext  = LUT_DEPTH'(survive_mask);
    next_state_c = 1'b0;
    if (count <= COUNT_WIDTH'(NUM_NEIGHBORS)) begin
      next_state_c = cur_state ? survive_ext[count] : birth_ext[count];
    end
  end

endmodule

// File: rtl/conway_rule_engine.sv
// Bit-serial neighbour accumulator + birth/survive rule, valid/ready in and out.
// Optional macro CONWAY_COUNT_OUT_EN exposes the final neighbour count as out_count.
module conway_rule_engine
  import conway_pkg::*;
#(
  parameter int unsigned             NUM_NEIGHBORS = CONWAY_NUM_NEIGHBORS,
  parameter int unsigned             COUNT_WIDTH   = CONWAY_COUNT_WIDTH,
  parameter logic [NUM_NEIGHBORS:0]  BIRTH_MASK    = CONWAY_B3S23_BIRTH,
  parameter logic [NUM_NEIGHBORS:0]  SURVIVE_MASK  = CONWAY_B3S23_SURVIVE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_nbr,
  input  logic                   in_last,
  input  logic                   in_cur_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_next_state,
  output logic                   out_overflow
`ifdef CONWAY_COUNT_OUT_EN
  ,
  output logic [COUNT_WIDTH-1:0] out_count
`endif
);

  localparam int unsigned            SUM_W   = COUNT_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  rule_state_t            state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] beats;
  logic                   ovf;

  logic [SUM_W-1:0]       cnt_sum;
  logic [SUM_W-1:0]       beats_sum;
  logic [COUNT_WIDTH-1:0] cnt_sat;
  logic [COUNT_WIDTH-1:0] beats_sat;
  logic                   ovf_next;
  logic                   in_fire;
  logic                   out_fire;
  logic                   lut_next_c;

  // Saturating count/beat increments for the beat being accepted this cycle.
  always_comb begin
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    cnt_sum   = {1'b0, cnt} + SUM_W'(in_nbr);
    beats_sum = {1'b0, beats} + SUM_W'(1);
    cnt_sat   = cnt_sum[COUNT_WIDTH] ? CNT_MAX : cnt_sum[COUNT_WIDTH-1:0];
    beats_sat = beats_sum[COUNT_WIDTH] ? CNT_MAX : beats_sum[COUNT_WIDTH-1:0];
    ovf_next  = ovf || (beats_sat > COUNT_WIDTH'(NUM_NEIGHBORS));
  end

  conway_rule_lut #(
    .NUM_NEIGHBORS (NUM_NEIGHBORS),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_lut (
    .count        (cnt_sat),
    .cur_state    (in_cur_state),
    .birth_mask   (BIRTH_MASK),
    .survive_mask (SURVIVE_MASK),
    .next_state_c (lut_next_c)
  );

  // cnt doubles as the held final count while a result is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      cnt            <= '0;
      beats          <= '0;
      ovf            <= 1'b0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_next_state <= 1'b0;
      out_overflow   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            cnt   <= cnt_sat;
            beats <= beats_sat;
            ovf   <= ovf_next;
            if (in_last) begin
              out_next_state <= lut_next_c;
              out_overflow   <= ovf_next;
              out_valid      <= 1'b1;
              in_ready       <= 1'b0;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            cnt       <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef CONWAY_COUNT_OUT_EN
  assign out_count = cnt;
`endif

endmodule

// File: tb/tb_conway_rule_engine.sv
// Directed scoreboard bench for conway_rule_engine (B3/S23, 8 neighbours).
module tb_conway_rule_engine;
  import conway_pkg::*;

  localparam logic [15:0] BIRTH_TBL = 16'h0008;
  localparam logic [15:0] SURV_TBL  = 16'h000C;

  typedef struct packed {
    logic          next;
    logic          ovf;
    conway_count_t count;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic in_nbr;
  logic in_last;
  logic in_cur_state;
  logic out_valid;
  logic out_ready;
  logic out_next_state;
  logic out_overflow;
`ifdef CONWAY_COUNT_OUT_EN
  logic [3:0] out_count;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  conway_rule_engine dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_nbr         (in_nbr),
    .in_last        (in_last),
    .in_cur_state   (in_cur_state),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_next_state (out_next_state),
    .out_overflow   (out_overflow)
`ifdef CONWAY_COUNT_OUT_EN
    ,
    .out_count      (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] bits, input int nb, input logic cur);
    int          ones;
    logic [15:0] b;
    logic [15:0] s;
    exp_t        e;
    ones = 0;
    b    = BIRTH_TBL;
    s    = SURV_TBL;
    for (int i = 0; i < nb; i++) ones += int'(bits[i]);
    e.count = (ones > 15) ? 4'hF : 4'(ones);
    e.ovf   = (nb > 8);
    e.next  = (e.count > 4'd8) ? 1'b0 : (cur ? s[e.count] : b[e.count]);
    return e;
  endfunction

  task automatic beat(input logic nbr, input logic last, input logic cur);
    int guard;
    guard        = 0;
    in_valid     = 1'b1;
    in_nbr       = nbr;
    in_last      = last;
    in_cur_state = cur;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_cell(input string tag, input logic [31:0] bits, input int nb,
                           input logic cur, input bit push);
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1 && push) sb.push_back(model(bits, nb, cur));
      beat(bits[i], (i == nb - 1), cur);
    end
    chk({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_valid_seen"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_next"}, 32'(out_next_state), 32'(e.next));
      chk({tag, "_ovf"}, 32'(out_overflow), 32'(e.ovf));
`ifdef CONWAY_COUNT_OUT_EN
      chk({tag, "_count"}, 32'(out_count), 32'(e.count));
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_nbr       = 1'b0;
    in_last      = 1'b0;
    in_cur_state = 1'b0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_next", 32'(out_next_state), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
`ifdef CONWAY_COUNT_OUT_EN
    chk("rst_count", 32'(out_count), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    send_cell("b3", 32'h0000_0007, 8, 1'b0, 1'b1);
    collect("b3");
    send_cell("s2", 32'h0000_0003, 8, 1'b1, 1'b1);
    collect("s2");
    send_cell("dead2", 32'h0000_0003, 8, 1'b0, 1'b1);
    collect("dead2");
    send_cell("all8", 32'h0000_00FF, 8, 1'b1, 1'b1);
    collect("all8");

    // Stalled result: outputs must hold and a beat offered in HOLD is not taken.
    send_cell("stall", 32'h0000_0007, 8, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        in_nbr   = 1'b1;
        in_last  = 1'b0;
      end
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_next", 32'(out_next_state), 32'd1);
      chk("stall_ovf", 32'(out_overflow), 32'd0);
    end
    in_valid = 1'b0;
    in_nbr   = 1'b0;
    collect("stall");
    send_cell("after_stall", 32'h0000_0003, 8, 1'b0, 1'b1);
    collect("after_stall");

    send_cell("ovf10", 32'h0000_03FF, 10, 1'b1, 1'b1);
    collect("ovf10");
    send_cell("post_ovf", 32'h0000_0007, 8, 1'b0, 1'b1);
    collect("post_ovf");
    send_cell("ovf9_birth", 32'h0000_0007, 9, 1'b0, 1'b1);
    collect("ovf9_birth");
    send_cell("sat20", 32'h000F_FFFF, 20, 1'b1, 1'b1);
    collect("sat20");
    send_cell("single", 32'h0000_0001, 1, 1'b0, 1'b1);
    collect("single");

    // Reset with a partial count in flight.
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_accum_ready", 32'(in_ready), 32'd1);
    chk("rst_accum_valid", 32'(out_valid), 32'd0);
    send_cell("post_rst", 32'h0000_0007, 8, 1'b0, 1'b1);
    collect("post_rst");

    // Reset with a result pending: it must be dropped.
    send_cell("hold_drop", 32'h0000_0007, 3, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_ready", 32'(in_ready), 32'd1);
    send_cell("post_hold_rst", 32'h0000_0003, 2, 1'b1, 1'b1);
    collect("post_hold_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conway_rule_engine.md
Name: conway_rule_engine

Overview:
- Bit-serial consumer for neighbour-count arithmetic. Accepts one neighbour bit per beat over a valid/ready stream, accumulates the live-neighbour count, then applies the birth/survive rule to the cell's current state.
- Emits the cell's next state over a valid/ready output stream.
- Sits between the grid-scan sequencer (neighbour bit producer) and the next-generation cell write-back.

Parameters:
- NUM_NEIGHBORS, 8, maximum legal neighbour beats per cell.
- COUNT_WIDTH, 4, accumulator width; must satisfy 2**COUNT_WIDTH > NUM_NEIGHBORS.
- BIRTH_MASK, 9'b0_0000_1000, bit k set means a dead cell with k neighbours becomes live (B3).
- SURVIVE_MASK, 9'b0_0000_1100, bit k set means a live cell with k neighbours stays live (S23).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  neighbour beat valid.
- in_ready  output  1  engine accepts a beat.
- in_nbr  input  1  neighbour alive bit.
- in_last  input  1  final neighbour beat for this cell.
- in_cur_state  input  1  current cell state; sampled only on the in_last beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_next_state  output  1  next cell state.
- out_overflow  output  1  this result saw more than NUM_NEIGHBORS beats.
- out_count  output  COUNT_WIDTH  final neighbour count; present only with CONWAY_COUNT_OUT_EN.

Behaviour:
- Reset state is ACCUM with the counter cleared. Reset values: in_ready=1, out_valid=0, out_next_state=0, out_overflow=0, out_count=0.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- There are two states, ACCUM and HOLD.
- ACCUM behaviour:
  - in_ready=1 and out_valid=0.
  - On each transfer, cnt += in_nbr. The add saturates at 2**COUNT_WIDTH-1.
  - On each transfer, beats += 1, also saturating. If beats would exceed NUM_NEIGHBORS, the overflow flag is set.
  - On a transfer with in_last=1, the engine computes the final count and result registers, then moves to HOLD.
  - The final count includes the in_nbr of the last beat.
- Result rule (final count = n):
  - n > NUM_NEIGHBORS: next = 0.
  - cur_state=1: next = SURVIVE_MASK[n].
  - cur_state=0: next = BIRTH_MASK[n].
- Latency and outputs:
  - The last beat is accepted at cycle T; out_valid rises at T+1 (registered, no combinational input-to-output path).
  - All out_* signals are registered and stable while out_valid=1 and out_ready=0.
- HOLD behaviour:
  - in_ready=0 and out_valid=1.
  - On an output transfer, the engine clears cnt, beats and overflow, returns to ACCUM, and drives out_valid=0 the next cycle.
  - in_ready returns to 1 in the cycle after the output transfer. There is exactly one bubble between cells; there is no same-cycle bypass.
- Boundary conditions:
  - An in_last beat as the first beat is legal: a single-beat cell, n = in_nbr.
  - A cell with zero neighbour beats cannot occur; every cell ends with an in_last beat.
  - in_valid while in HOLD is ignored; the producer must keep holding its beat.
- Reset mid-operation: a partial count is discarded and a pending result is dropped. out_valid falls in the cycle after rst is sampled high.

Optional Feature:
- Macro: CONWAY_COUNT_OUT_EN.
- Defined: the out_count port exists and carries the saturated final count, registered alongside out_next_state.
- Undefined: the port is absent and the count register is internal only. Rule behaviour is identical in both cases.

Decomposition:
- Shared package conway_pkg holds:
  - typedef conway_count_t (logic [COUNT_WIDTH-1:0], COUNT_WIDTH=4);
  - localparams CONWAY_B3S23_BIRTH and CONWAY_B3S23_SURVIVE;
  - enum rule_state_t {ACCUM, HOLD}.
- Sub-module conway_rule_lut: combinational (count, cur_state, masks) -> next_state, including the n > NUM_NEIGHBORS -> 0 rule.
- Accumulator and FSM stay in the top module.

Test Plan:
- Nbr bits 1,1,1,0,0,0,0,0 (last on beat 8), cur=0, out_ready=1 -> out_valid=1 one cycle after last; next=1; count=3.
- Nbr bits 1,1,0,0,0,0,0,0, cur=1 -> next=1. Same bits with cur=0 -> next=0. All 8 ones with cur=1 -> next=0, count=8.
- Result with out_ready held low 5 cycles, then in_valid pulsed -> in_ready=0, outputs stable throughout, no beat consumed. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- 10 beats of 1, last on the 10th, cur=1 -> overflow=1, next=0, count=10. The following normal cell has overflow=0.
- Single beat in_nbr=1, in_last=1, cur=0 -> next=0, count=1.
- rst asserted after 4 beats -> after reset, a new 8-beat cell with 3 ones and cur=0 yields next=1, count=3, with no residue from the partial cell.
